// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous snapshot.
// Define DISP_SCAN_BLANK_EN to insert BLANK_CYCLES of dark time between digits.
module disp_scan_ctrl #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        direction,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit,
  output logic        frame
);

  if (PRESCALE < 2 || PRESCALE > 65535 ||
      BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_param
    $error("disp_scan_ctrl: parameter out of range");
  end

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [1:0]  digit_q, digit_d, digit_nx;
  logic        frame_q, frame_d;
  logic [15:0] sval_q, sval_d;
  logic [3:0]  sdp_q, sdp_d;
  logic        show, tick, adv, wrap;
  logic [3:0]  nib;

`ifdef DISP_SCAN_BLANK_EN
  typedef enum logic {SHOW, BLANK} state_e;
  localparam logic [7:0] BL_MAX = 8'(BLANK_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] blank_q, blank_d;

  assign show = (state_q == SHOW);
  assign adv  = en && !show && (blank_q == BL_MAX);
`else
  assign show = 1'b1;
  assign adv  = tick;
`endif

  assign tick     = en && show && (presc_q == PS_MAX);
  assign digit_nx = direction ? digit_q - 2'd1 : digit_q + 2'd1;
  assign wrap     = direction ? (digit_q == 2'd0) : (digit_q == 2'd3);

  always_comb begin
    presc_d = presc_q;
    if (tick)
      presc_d = '0;
    else if (en && show)
      presc_d = presc_q + 16'd1;
    digit_d = adv ? digit_nx : digit_q;
    frame_d = adv && wrap;
    sval_d  = sval_q;
    sdp_d   = sdp_q;
    // Snapshot once per frame so a digit never shows a torn value
    if (frame_q || !en) begin
      sval_d = value;
      sdp_d  = dp;
    end
  end

`ifdef DISP_SCAN_BLANK_EN
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    if (tick) begin
      state_d = BLANK;
    end else if (adv) begin
      state_d = SHOW;
      blank_d = '0;
    end else if (en && !show) begin
      blank_d = blank_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= '0;
      frame_q <= 1'b0;
      sval_q  <= '0;
      sdp_q   <= '0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
      sval_q  <= sval_d;
      sdp_q   <= sdp_d;
    end
  end

  assign nib = sval_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  assign an    = show ? ~(4'b0001 << digit_q) : 4'b1111;
  assign dp_n  = show ? ~sdp_q[digit_q] : 1'b1;
  assign digit = digit_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl at PRESCALE=4, BLANK_CYCLES=2.
// Build with DISP_SCAN_BLANK_EN defined to exercise the blanking variant.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, direction;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic [1:0]  digit;
  logic        frame;

  int errs = 0;
  int checks = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;

  disp_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .direction(direction),
    .value(value), .dp(dp), .an(an), .seg(seg), .dp_n(dp_n),
    .digit(digit), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; direction = 1'b0;
    value = 16'h1234; dp = 4'h0;
    step(2);
    checks += 5;
    if (an !== 4'b1110) begin errs++; $display("FAIL rst_an: got %b want 1110", an); end
    if (seg !== G0) begin errs++; $display("FAIL rst_seg: got %b want %b", seg, G0); end
    if (frame !== 1'b0) begin errs++; $display("FAIL rst_frame: got %b want 0", frame); end
    if (dp_n !== 1'b1) begin errs++; $display("FAIL rst_dpn: got %b want 1", dp_n); end
    if (digit !== 2'd0) begin errs++; $display("FAIL rst_digit: got %0d want 0", digit); end
    rst = 1'b0;
    step(1);
    checks += 2;
    if (seg !== G4) begin errs++; $display("FAIL rst_snap_seg: got %b want %b", seg, G4); end
    if (an !== 4'b1110) begin errs++; $display("FAIL rst_snap_an: got %b want 1110", an); end
  endtask

  task automatic test_forward;
    logic [6:0] gl [4];
    logic [3:0] ean;
    int d;
    gl[0] = G4; gl[1] = G3; gl[2] = G2; gl[3] = G1;
    direction = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step(1);
      d = (k / 4) % 4;
      ean = 4'b1111;
      ean[d] = 1'b0;
      checks += 4;
      if (an !== ean) begin errs++; $display("FAIL fwd_an k=%0d: got %b want %b", k, an, ean); end
      if (seg !== gl[d]) begin errs++; $display("FAIL fwd_seg k=%0d: got %b want %b", k, seg, gl[d]); end
      if (frame !== (k == 16)) begin errs++; $display("FAIL fwd_frame k=%0d: got %b want %b", k, frame, k == 16); end
      if (dp_n !== 1'b1) begin errs++; $display("FAIL fwd_dpn k=%0d: got %b want 1", k, dp_n); end
    end
  endtask

  task automatic test_reverse;
    direction = 1'b1;
    step(1);
    checks += 3;
    if (an !== 4'b0111) begin errs++; $display("FAIL rev_an: got %b want 0111", an); end
    if (digit !== 2'd3) begin errs++; $display("FAIL rev_digit: got %0d want 3", digit); end
    if (frame !== 1'b1) begin errs++; $display("FAIL rev_frame: got %b want 1", frame); end
    step(1);
    checks += 2;
    if (frame !== 1'b0) begin errs++; $display("FAIL rev_frame_end: got %b want 0", frame); end
    if (seg !== G1) begin errs++; $display("FAIL rev_seg: got %b want %b", seg, G1); end
    step(2);
    checks += 1;
    if (digit !== 2'd3) begin errs++; $display("FAIL rev_hold: got %0d want 3", digit); end
    step(1);
    checks += 2;
    if (digit !== 2'd2) begin errs++; $display("FAIL rev_next: got %0d want 2", digit); end
    if (an !== 4'b1011) begin errs++; $display("FAIL rev_next_an: got %b want 1011", an); end
  endtask

  task automatic test_freeze;
    step(1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks += 1;
      if (an !== 4'b1011) begin errs++; $display("FAIL frz_an i=%0d: got %b want 1011", i, an); end
    end
    en = 1'b1;
    step(2);
    checks += 1;
    if (digit !== 2'd2) begin errs++; $display("FAIL frz_len: got %0d want 2", digit); end
    step(1);
    checks += 2;
    if (digit !== 2'd1) begin errs++; $display("FAIL frz_next: got %0d want 1", digit); end
    if (an !== 4'b1101) begin errs++; $display("FAIL frz_next_an: got %b want 1101", an); end
  endtask

  task automatic test_snapshot;
    direction = 1'b0;
    step(3);
    checks += 1;
    if (digit !== 2'd1) begin errs++; $display("FAIL dir_mid_slot: got %0d want 1", digit); end
    step(1);
    checks += 1;
    if (digit !== 2'd2) begin errs++; $display("FAIL dir_adv: got %0d want 2", digit); end
    value = 16'hABCD;
    dp = 4'b0100;
    step(1);
    checks += 2;
    if (seg !== G2) begin errs++; $display("FAIL snap_old2: got %b want %b", seg, G2); end
    if (dp_n !== 1'b1) begin errs++; $display("FAIL snap_olddp: got %b want 1", dp_n); end
    step(4);
    checks += 1;
    if (seg !== G1) begin errs++; $display("FAIL snap_old1: got %b want %b", seg, G1); end
    step(3);
    checks += 2;
    if (frame !== 1'b1) begin errs++; $display("FAIL snap_frame: got %b want 1", frame); end
    if (digit !== 2'd0) begin errs++; $display("FAIL snap_wrap: got %0d want 0", digit); end
    step(1);
    checks += 2;
    if (seg !== GD) begin errs++; $display("FAIL snap_D: got %b want %b", seg, GD); end
    if (dp_n !== 1'b1) begin errs++; $display("FAIL snap_dp0: got %b want 1", dp_n); end
    step(4);
    checks += 1;
    if (seg !== GC) begin errs++; $display("FAIL snap_C: got %b want %b", seg, GC); end
    step(4);
    checks += 3;
    if (seg !== GB) begin errs++; $display("FAIL snap_B: got %b want %b", seg, GB); end
    if (dp_n !== 1'b0) begin errs++; $display("FAIL snap_dp2: got %b want 0", dp_n); end
    if (an !== 4'b1011) begin errs++; $display("FAIL snap_an2: got %b want 1011", an); end
    step(4);
    checks += 3;
    if (seg !== GA) begin errs++; $display("FAIL snap_A: got %b want %b", seg, GA); end
    if (an !== 4'b0111) begin errs++; $display("FAIL snap_an3: got %b want 0111", an); end
    if (dp_n !== 1'b1) begin errs++; $display("FAIL snap_dp3: got %b want 1", dp_n); end
  endtask

  task automatic test_blank;
    logic [3:0] ean;
    logic       edp;
    int s, p;
    dp = 4'hF;
    step(1);
    direction = 1'b0;
    en = 1'b1;
    for (int k = 0; k <= 48; k++) begin
      if (k > 0) step(1);
      s = (k / 6) % 4;
      p = k % 6;
      ean = 4'b1111;
      if (p < 4) ean[s] = 1'b0;
      edp = (p >= 4);
      checks += 3;
      if (an !== ean) begin errs++; $display("FAIL blk_an k=%0d: got %b want %b", k, an, ean); end
      if (dp_n !== edp) begin errs++; $display("FAIL blk_dpn k=%0d: got %b want %b", k, dp_n, edp); end
      if (frame !== (k == 24 || k == 48)) begin
        errs++; $display("FAIL blk_frame k=%0d: got %b want %b", k, frame, k == 24 || k == 48);
      end
    end
  endtask

  task automatic test_reset_mid_slot;
    logic [3:0] enext;
`ifdef DISP_SCAN_BLANK_EN
    int n = 0;
    enext = 4'b1111;
    while (an !== 4'b1111 && n < 20) begin
      step(1);
      n++;
    end
    checks += 1;
    if (an !== 4'b1111) begin errs++; $display("FAIL rmid_find_blank: got %b want 1111", an); end
`else
    enext = 4'b1101;
    step(2);
`endif
    rst = 1'b1;
    step(1);
    checks += 4;
    if (an !== 4'b1110) begin errs++; $display("FAIL rmid_an: got %b want 1110", an); end
    if (digit !== 2'd0) begin errs++; $display("FAIL rmid_digit: got %0d want 0", digit); end
    if (frame !== 1'b0) begin errs++; $display("FAIL rmid_frame: got %b want 0", frame); end
    if (seg !== G0) begin errs++; $display("FAIL rmid_seg: got %b want %b", seg, G0); end
    rst = 1'b0;
    step(3);
    checks += 3;
    if (an !== 4'b1110) begin errs++; $display("FAIL rmid_hold: got %b want 1110", an); end
    if (frame !== 1'b0) begin errs++; $display("FAIL rmid_noframe: got %b want 0", frame); end
    if (seg !== G0) begin errs++; $display("FAIL rmid_shadow: got %b want %b", seg, G0); end
    step(1);
    checks += 1;
    if (an !== enext) begin errs++; $display("FAIL rmid_next: got %b want %b", an, enext); end
  endtask

  initial begin
    test_reset();
`ifdef DISP_SCAN_BLANK_EN
    test_blank();
`else
    test_forward();
    test_reverse();
    test_freeze();
    test_snapshot();
`endif
    test_reset_mid_slot();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, 1000: clocks per lit digit slot; legal range 2..65535.
REQ-002 Parameter BLANK_CYCLES, 16: dead-time clocks between digits when blanking is compiled in; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 1: scan enable; low freezes the scan.
REQ-006 Port direction, input, 1: 0 scans digit index upward, 1 scans downward.
REQ-007 Port value, input, 16: four hex digits; digit i is value[4i+3:4i].
REQ-008 Port dp, input, 4: decimal point request per digit, active-high.
REQ-009 Port an, output, 4: digit anodes, active-low one-hot; an[i] low lights digit i.
REQ-010 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port dp_n, output, 1: decimal point, active-low.
REQ-012 Port digit, output, 2: index of the current digit.
REQ-013 Port frame, output, 1: single-cycle pulse on index wrap.

Function
REQ-014 All outputs SHALL be decoded from registers only; there is no combinational path from any input to any output.
REQ-015 A prescaler SHALL count 0..PRESCALE-1 while en=1 and state is SHOW; a tick SHALL occur in the cycle where the count equals PRESCALE-1.
REQ-016 The FSM SHALL have two states, SHOW and BLANK; in SHOW, an SHALL equal ~(1<<digit).
REQ-017 On a tick, the next state SHALL be BLANK (macro defined) or the index SHALL advance directly (macro undefined); the prescaler SHALL return to 0.
REQ-018 Advance SHALL be digit+1 mod 4 when direction=0 and digit-1 mod 4 when direction=1; direction is sampled only at the advance edge.
REQ-019 frame SHALL pulse high for exactly one cycle after an advance from 3 to 0 (direction=0) or from 0 to 3 (direction=1).
REQ-020 value and dp SHALL be copied into shadow registers on the cycle frame is high and on every cycle with en=0; seg and dp_n SHALL be decoded from the shadow registers only.
REQ-021 Hex glyphs, 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-022 dp_n SHALL equal ~shadow_dp[digit] in SHOW and 1 in BLANK.
REQ-023 en=0 SHALL hold the prescaler, blank counter, state and index; the lit digit SHALL stay lit, and the slot SHALL resume where it stopped.
REQ-024 A direction change mid-slot SHALL NOT shorten or repeat the current slot.

Reset
REQ-025 rst=1 SHALL force: state SHOW, prescaler 0, blank counter 0, digit 0, shadow value 0, shadow dp 0.
REQ-026 During and after reset: an=4'b1110, seg=7'b1000000, dp_n=1, frame=0.
REQ-027 rst SHALL override en and any in-progress slot or blank interval.

Configuration
REQ-028 The macro DISP_SCAN_BLANK_EN SHALL control inter-digit blanking.
REQ-029 With DISP_SCAN_BLANK_EN defined: after a tick the block SHALL enter BLANK with an=4'b1111 for BLANK_CYCLES en-qualified cycles, then advance the index and return to SHOW; slot period is PRESCALE+BLANK_CYCLES.
REQ-030 With DISP_SCAN_BLANK_EN undefined: the BLANK state and its counter SHALL be absent; slot period is PRESCALE, and an SHALL never be 4'b1111.

Verification (PRESCALE=4, BLANK_CYCLES=2)
REQ-031 Reset: rst=1 for 2 cycles with value=16'h1234 -> an=1110, seg=1000000, frame=0. Then rst=0, en=0 -> one cycle later seg=0011001 ('4').
REQ-032 Forward scan, macro undefined, en=1, direction=0 -> an cycles 1110, 1101, 1011, 0111, 1110, 4 cycles each. seg shows 4, 3, 2, 1. frame is high for exactly 1 cycle on the return to digit 0.
REQ-033 Reverse scan: direction=1 set while digit=0 -> next digit=3, an=0111. frame pulses on the 0->3 advance.
REQ-034 Blanking, macro defined -> an=1111 and dp_n=1 for exactly 2 cycles between lit slots; frame-to-frame spacing is 24 cycles.
REQ-035 Freeze and snapshot: en=0 for 10 cycles mid-slot -> an unchanged and the slot lasts 14 cycles. Then value 1234->ABCD mid-frame with en=1 -> the remaining digits of this frame show 1234, and the next frame shows D, C, B, A (digit 3 seg=0001000).
REQ-036 Reset mid-BLANK (macro defined) -> the next cycle shows an=1110, digit=0, prescaler 0, with no frame pulse.
